// File: rtl/adc_cfg_arbiter_pkg.sv
// adc_cfg_arbiter_pkg: shared state encoding, owner codes and the
// round-robin winner helper for the ADC configuration-engine arbiter.
package adc_cfg_arbiter_pkg;

  // Gray-ordered so each legal transition flips a single bit.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_GRANT = 2'b01,
    ST_WAIT  = 2'b11,
    ST_DONE  = 2'b10
  } state_t;

  localparam logic OWN_AUTO = 1'b0;
  localparam logic OWN_SC   = 1'b1;

  localparam int DEFAULT_DATA_W = 24;

  // Picks the requester to serve. On a tie the one that did not own the
  // engine last time wins, so neither side can be starved.
  function automatic logic pick_winner(input logic auto_req,
                                       input logic sc_req,
                                       input logic last_owner);
    logic win;
    if (auto_req && sc_req) begin
      win = ~last_owner;
    end else if (sc_req) begin
      win = OWN_SC;
    end else begin
      win = OWN_AUTO;
    end
    return win;
  endfunction

endpackage

// File: rtl/adc_cfg_watchdog.sv
// adc_cfg_watchdog: cycle counter that flags when a transfer has been
// outstanding for LIMIT cycles. Cleared whenever clr is high, counts while
// en is high. expire is asserted during the LIMIT-th enabled cycle, so the
// caller's registered reaction lands exactly LIMIT cycles after counting began.
// LIMIT must be at least 1 and below 2**W.
module adc_cfg_watchdog #(
  parameter int LIMIT = 4095,
  parameter int W     = 12
) (
  input  logic clk,
  input  logic rstb,
  input  logic clr,
  input  logic en,
  output logic expire
);

  localparam logic [W-1:0] LAST = W'(LIMIT - 1);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  // Next count: clear has priority, otherwise increment while enabled.
  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (en) begin
      count_d = count_q + W'(1);
    end
  end

  // Counter register.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign expire = en && (count_q == LAST);

endmodule

// File: rtl/adc_cfg_arbiter.sv
// adc_cfg_arbiter: shares one ADC serial-configuration engine between the
// power-up auto sequencer and slow-control writes. IDLE -> GRANT (start
// pulse, word latched) -> WAIT (for cfg_end) -> DONE (done pulse) -> IDLE.
// All outputs are registered. adc_rst flushes back to IDLE from any state.
// Build option: define ADCARB_TIMEOUT_EN to include a WAIT watchdog that
// forces completion with an err_to pulse after TO_CYCLES cycles; without it
// err_to stays 0 and WAIT lasts until cfg_end or adc_rst.
module adc_cfg_arbiter
  import adc_cfg_arbiter_pkg::*;
#(
  parameter int DATA_W    = DEFAULT_DATA_W,
  parameter int TO_CYCLES = 4095,
  parameter int TO_W      = 12
) (
  input  logic              clk,
  input  logic              rstb,
  input  logic              adc_rst,
  input  logic              auto_req,
  input  logic [DATA_W-1:0] auto_data,
  output logic              auto_gnt,
  output logic              auto_done,
  input  logic              sc_req,
  input  logic [DATA_W-1:0] sc_data,
  output logic              sc_gnt,
  output logic              sc_done,
  output logic              cfg_start,
  output logic [DATA_W-1:0] cfg_data,
  input  logic              cfg_end,
  output logic              busy,
  output logic              owner,
  output logic              err_to
);

  state_t            state_q, state_d;
  logic              owner_q, owner_d;
  logic [DATA_W-1:0] cfg_data_q, cfg_data_d;
  logic              auto_gnt_q, auto_gnt_d;
  logic              sc_gnt_q, sc_gnt_d;
  logic              auto_done_q, auto_done_d;
  logic              sc_done_q, sc_done_d;
  logic              cfg_start_q, cfg_start_d;
  logic              busy_q, busy_d;
  logic              err_to_q, err_to_d;

  logic              winner;
  logic              to_expire;

  assign winner = pick_winner(auto_req, sc_req, owner_q);

`ifdef ADCARB_TIMEOUT_EN
  logic to_clr;
  logic to_en;

  // The watchdog only runs in WAIT and restarts from zero on every entry.
  assign to_en  = (state_q == ST_WAIT);
  assign to_clr = adc_rst || (state_q != ST_WAIT);

  adc_cfg_watchdog #(
    .LIMIT (TO_CYCLES),
    .W     (TO_W)
  ) u_watchdog (
    .clk    (clk),
    .rstb   (rstb),
    .clr    (to_clr),
    .en     (to_en),
    .expire (to_expire)
  );
`else
  // No watchdog: the timeout limit is only sanity-checked, never acted on.
  localparam logic TO_CFG_OK = (TO_CYCLES >= 1) && (TO_CYCLES < (2 ** TO_W));
  assign to_expire = TO_CFG_OK & 1'b0;
`endif

  // Next-state and next-output logic; outputs are precomputed so they
  // appear registered in the same cycle as the state they belong to.
  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    cfg_data_d  = cfg_data_q;
    auto_gnt_d  = auto_gnt_q;
    sc_gnt_d    = sc_gnt_q;
    busy_d      = busy_q;
    auto_done_d = 1'b0;
    sc_done_d   = 1'b0;
    cfg_start_d = 1'b0;
    err_to_d    = 1'b0;

    if (adc_rst) begin
      // Flush wins over cfg_end, timeout and new requests; owner and the
      // last word are deliberately kept for debug visibility.
      state_d    = ST_IDLE;
      auto_gnt_d = 1'b0;
      sc_gnt_d   = 1'b0;
      busy_d     = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          auto_gnt_d = 1'b0;
          sc_gnt_d   = 1'b0;
          busy_d     = 1'b0;
          if (auto_req || sc_req) begin
            state_d     = ST_GRANT;
            owner_d     = winner;
            cfg_data_d  = (winner == OWN_SC) ? sc_data : auto_data;
            cfg_start_d = 1'b1;
            auto_gnt_d  = (winner == OWN_AUTO);
            sc_gnt_d    = (winner == OWN_SC);
            busy_d      = 1'b1;
          end
        end

        ST_GRANT: begin
          // A cfg_end here belongs to no transfer of ours and is ignored.
          state_d = ST_WAIT;
        end

        ST_WAIT: begin
          if (cfg_end || to_expire) begin
            state_d     = ST_DONE;
            auto_gnt_d  = 1'b0;
            sc_gnt_d    = 1'b0;
            auto_done_d = (owner_q == OWN_AUTO);
            sc_done_d   = (owner_q == OWN_SC);
            // A real end in the same cycle as expiry is a normal completion.
            err_to_d    = to_expire && !cfg_end;
          end
        end

        ST_DONE: begin
          state_d = ST_IDLE;
          busy_d  = 1'b0;
        end

        default: begin
          state_d    = ST_IDLE;
          auto_gnt_d = 1'b0;
          sc_gnt_d   = 1'b0;
          busy_d     = 1'b0;
        end
      endcase
    end
  end

  // State and registered outputs.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state_q     <= ST_IDLE;
      owner_q     <= OWN_SC;
      cfg_data_q  <= '0;
      auto_gnt_q  <= 1'b0;
      sc_gnt_q    <= 1'b0;
      auto_done_q <= 1'b0;
      sc_done_q   <= 1'b0;
      cfg_start_q <= 1'b0;
      busy_q      <= 1'b0;
      err_to_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      cfg_data_q  <= cfg_data_d;
      auto_gnt_q  <= auto_gnt_d;
      sc_gnt_q    <= sc_gnt_d;
      auto_done_q <= auto_done_d;
      sc_done_q   <= sc_done_d;
      cfg_start_q <= cfg_start_d;
      busy_q      <= busy_d;
      err_to_q    <= err_to_d;
    end
  end

  assign auto_gnt  = auto_gnt_q;
  assign sc_gnt    = sc_gnt_q;
  assign auto_done = auto_done_q;
  assign sc_done   = sc_done_q;
  assign cfg_start = cfg_start_q;
  assign cfg_data  = cfg_data_q;
  assign busy      = busy_q;
  assign owner     = owner_q;
  assign err_to    = err_to_q;

endmodule

// File: tb/tb_adc_cfg_arbiter.sv
// tb_adc_cfg_arbiter: directed cycle-by-cycle vectors for arbitration,
// round-robin, flush and stray-cfg_end cases, plus hand sequences for a
// long engine latency and the watchdog (or its absence).
module tb_adc_cfg_arbiter;

  localparam int DW = 24;

  logic          clk;
  logic          rstb;
  logic          adc_rst;
  logic          auto_req;
  logic [DW-1:0] auto_data;
  logic          auto_gnt;
  logic          auto_done;
  logic          sc_req;
  logic [DW-1:0] sc_data;
  logic          sc_gnt;
  logic          sc_done;
  logic          cfg_start;
  logic [DW-1:0] cfg_data;
  logic          cfg_end;
  logic          busy;
  logic          owner;
  logic          err_to;

  int checks   = 0;
  int failures = 0;

  adc_cfg_arbiter #(
    .DATA_W    (DW),
    .TO_CYCLES (15),
    .TO_W      (4)
  ) dut (
    .clk       (clk),
    .rstb      (rstb),
    .adc_rst   (adc_rst),
    .auto_req  (auto_req),
    .auto_data (auto_data),
    .auto_gnt  (auto_gnt),
    .auto_done (auto_done),
    .sc_req    (sc_req),
    .sc_data   (sc_data),
    .sc_gnt    (sc_gnt),
    .sc_done   (sc_done),
    .cfg_start (cfg_start),
    .cfg_data  (cfg_data),
    .cfg_end   (cfg_end),
    .busy      (busy),
    .owner     (owner),
    .err_to    (err_to)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic          ar;
    logic          sr;
    logic          rst;
    logic          cend;
    logic [DW-1:0] ad;
    logic [DW-1:0] sd;
    logic [31:0]   exp;
  } vec_t;

  vec_t vecs[$];

  localparam logic [DW-1:0] A  = 24'h0A1234;
  localparam logic [DW-1:0] S  = 24'h85BEEF;
  localparam logic [DW-1:0] A2 = 24'h1C0055;
  localparam logic [DW-1:0] S2 = 24'h2D00AA;
  localparam logic [DW-1:0] A3 = 24'h03C0DE;

  // Output word layout: ag sg ad sd start busy owner err_to | cfg_data
  function automatic logic [31:0] outw(logic ag, logic sg, logic ad, logic sd,
                                       logic st, logic b, logic ow, logic e,
                                       logic [DW-1:0] d);
    return {ag, sg, ad, sd, st, b, ow, e, d};
  endfunction

  function automatic void add(logic ar, logic sr, logic rst, logic ce,
                              logic [DW-1:0] ad, logic [DW-1:0] sd,
                              logic ag, logic sg, logic ado, logic sdo,
                              logic st, logic b, logic ow, logic e,
                              logic [DW-1:0] d);
    vec_t v;
    v.ar = ar; v.sr = sr; v.rst = rst; v.cend = ce;
    v.ad = ad; v.sd = sd;
    v.exp = outw(ag, sg, ado, sdo, st, b, ow, e, d);
    vecs.push_back(v);
  endfunction

  function automatic logic [31:0] got_w();
    return {auto_gnt, sc_gnt, auto_done, sc_done, cfg_start, busy, owner, err_to, cfg_data};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  initial begin
    logic seen_bad;
    logic seen_done;
    int   n;

    // Simultaneous first requests: auto wins the first tie, then sc.
    add(1,1,0,0, A,S,   1,0,0,0,1,1,0,0, A);
    add(1,1,0,0, A,S,   1,0,0,0,0,1,0,0, A);
    add(1,1,0,1, A,S,   0,0,1,0,0,1,0,0, A);
    add(0,1,0,0, A,S,   0,0,0,0,0,0,0,0, A);
    add(0,1,0,0, A,S,   0,1,0,0,1,1,1,0, S);
    add(0,1,0,1, A,S,   0,1,0,0,0,1,1,0, S);   // cfg_end in GRANT ignored
    add(0,1,0,0, A,S,   0,1,0,0,0,1,1,0, S);
    add(0,1,0,1, A,S,   0,0,0,1,0,1,1,0, S);
    add(0,0,0,0, A,S,   0,0,0,0,0,0,1,0, S);
    // Continuous contention: auto, sc, auto, sc with both held.
    add(1,1,0,0, A2,S2, 1,0,0,0,1,1,0,0, A2);
    add(1,1,0,0, A2,S2, 1,0,0,0,0,1,0,0, A2);
    add(1,1,0,1, A2,S2, 0,0,1,0,0,1,0,0, A2);
    add(1,1,0,0, A2,S2, 0,0,0,0,0,0,0,0, A2);
    add(1,1,0,0, A2,S2, 0,1,0,0,1,1,1,0, S2);
    add(1,1,0,0, A2,S2, 0,1,0,0,0,1,1,0, S2);
    add(1,1,0,1, A2,S2, 0,0,0,1,0,1,1,0, S2);
    add(1,1,0,0, A2,S2, 0,0,0,0,0,0,1,0, S2);
    add(1,1,0,0, A3,S,  1,0,0,0,1,1,0,0, A3);
    add(1,1,0,0, A3,S,  1,0,0,0,0,1,0,0, A3);
    add(1,1,0,1, A3,S,  0,0,1,0,0,1,0,0, A3);
    add(1,1,0,0, A3,S,  0,0,0,0,0,0,0,0, A3);
    add(1,1,0,0, A3,S,  0,1,0,0,1,1,1,0, S);
    add(1,1,0,0, A3,S,  0,1,0,0,0,1,1,0, S);
    add(1,1,0,1, A3,S,  0,0,0,1,0,1,1,0, S);
    add(0,0,0,0, A3,S,  0,0,0,0,0,0,1,0, S);
    // adc_rst three cycles after cfg_start, beating a same-cycle cfg_end.
    add(1,0,0,0, A,S,   1,0,0,0,1,1,0,0, A);
    add(1,0,0,0, A,S,   1,0,0,0,0,1,0,0, A);
    add(1,0,0,0, A,S,   1,0,0,0,0,1,0,0, A);
    add(1,0,0,0, A,S,   1,0,0,0,0,1,0,0, A);
    add(1,0,1,1, A,S,   0,0,0,0,0,0,0,0, A);
    add(0,1,1,0, A,S,   0,0,0,0,0,0,0,0, A);   // adc_rst blocks grant in IDLE
    add(0,0,0,0, A,S,   0,0,0,0,0,0,0,0, A);
    // Re-issued request restarts normally.
    add(1,0,0,0, A3,S,  1,0,0,0,1,1,0,0, A3);
    add(1,0,0,1, A3,S,  1,0,0,0,0,1,0,0, A3);
    add(1,0,0,1, A3,S,  0,0,1,0,0,1,0,0, A3);
    add(0,0,0,0, A3,S,  0,0,0,0,0,0,0,0, A3);

    rstb = 1'b0; adc_rst = 1'b0; cfg_end = 1'b0;
    auto_req = 1'b0; sc_req = 1'b0; auto_data = '0; sc_data = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset", got_w(), outw(0,0,0,0,0,0,1,0, 24'h0));
    rstb = 1'b1;
    tick();
    check("idle_after_reset", got_w(), outw(0,0,0,0,0,0,1,0, 24'h0));

    for (int i = 0; i < vecs.size(); i++) begin
      auto_req  = vecs[i].ar;
      sc_req    = vecs[i].sr;
      adc_rst   = vecs[i].rst;
      cfg_end   = vecs[i].cend;
      auto_data = vecs[i].ad;
      sc_data   = vecs[i].sd;
      tick();
      check($sformatf("vec%0d", i), got_w(), vecs[i].exp);
    end
    auto_req = 1'b0; sc_req = 1'b0; adc_rst = 1'b0; cfg_end = 1'b0;

    // Single auto, engine answers 10 cycles after start.
    auto_req = 1'b1; auto_data = A; sc_data = S;
    tick();
    check("single_start", got_w(), outw(1,0,0,0,1,1,0,0, A));
    seen_bad = 1'b0;
    for (int k = 1; k < 10; k++) begin
      tick();
      if (sc_gnt || auto_done || cfg_start || !auto_gnt || cfg_data !== A) seen_bad = 1'b1;
    end
    check("single_wait_hold", {31'b0, seen_bad}, 32'h0);
    cfg_end = 1'b1;
    tick();
    cfg_end = 1'b0; auto_req = 1'b0;
    check("single_done", got_w(), outw(0,0,1,0,0,1,0,0, A));
    tick();
    check("single_idle", got_w(), outw(0,0,0,0,0,0,0,0, A));

    // Engine never answers.
    auto_req = 1'b1; auto_data = A2;
    tick();   // GRANT
    tick();   // first WAIT cycle
`ifdef ADCARB_TIMEOUT_EN
    seen_done = 1'b0;
    n = 0;
    while (!seen_done && n < 40) begin
      tick();
      n++;
      if (auto_done) seen_done = 1'b1;
    end
    auto_req = 1'b0;
    check("timeout_done_err", {30'b0, auto_done, err_to}, 32'h3);
    check("timeout_cycles", 32'(n), 32'd15);
    tick();
    check("timeout_idle", got_w(), outw(0,0,0,0,0,0,0,0, A2));
`else
    seen_done = 1'b0;
    seen_bad  = 1'b0;
    for (int k = 0; k < 40; k++) begin
      tick();
      if (auto_done || err_to) seen_done = 1'b1;
      if (!busy || !auto_gnt) seen_bad = 1'b1;
    end
    check("no_timeout_busy", {30'b0, seen_done, seen_bad}, 32'h0);
    adc_rst = 1'b1; auto_req = 1'b0;
    tick();
    adc_rst = 1'b0;
    check("no_timeout_flush", got_w(), outw(0,0,0,0,0,0,0,0, A2));
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/adc_cfg_arbiter.md
# adc_cfg_arbiter

Arbitrates the single ADC serial-configuration engine between two requesters: the automatic power-up configuration sequencer and slow-control register writes. Grants one requester at a time, registers its word and pulses the engine's start, then waits for the engine's end-of-transfer strobe and returns a done pulse to the owner. Sits between the auto-config FSM / slow-control decoder and the serial shifter that drives the ADS5282 SPI pins.

## Interface
- DATA_W, 24, serial word width (8-bit address + 16-bit data)
- TO_CYCLES, 4095, watchdog limit in WAIT, clk cycles
- TO_W, 12, watchdog counter width; must satisfy 2^TO_W > TO_CYCLES
- clk  in  1  clock
- rstb  in  1  reset, asynchronous, active-low
- adc_rst  in  1  synchronous abort/flush; high for ≥1 cycle
- auto_req  in  1  auto sequencer request, level, held until auto_done
- auto_data  in  DATA_W  auto word, stable while auto_req high
- auto_gnt  out  1  auto owns engine
- auto_done  out  1  1-cycle completion pulse to auto
- sc_req  in  1  slow-control request, level
- sc_data  in  DATA_W  slow-control word
- sc_gnt  out  1  slow-control owns engine
- sc_done  out  1  1-cycle completion pulse to slow-control
- cfg_start  out  1  1-cycle start pulse to serial engine
- cfg_data  out  DATA_W  registered word to engine, held from start until done
- cfg_end  in  1  engine end-of-transfer strobe (1 cycle)
- busy  out  1  high in every state except IDLE
- owner  out  1  last/current owner: 0 auto, 1 slow-control
- err_to  out  1  1-cycle watchdog-timeout pulse

## Operation
- States: IDLE, GRANT, WAIT, DONE.
- IDLE: samples requests. None -> stay. One -> that requester wins. Both -> round-robin: winner is the requester that is not `owner`. Transition to GRANT; latch winner into owner, winner's data into cfg_data.
- GRANT: cfg_start=1, winner's gnt=1; -> WAIT unconditionally. cfg_end in GRANT is ignored.
- WAIT: gnt held; cfg_end=1 -> DONE. Watchdog (when compiled in) counts from 0; count == TO_CYCLES -> DONE with err_to=1.
- DONE: owner's done=1, gnt dropped this cycle; -> IDLE.
- Requests are sampled only in IDLE; a req still high in DONE is not taken. A req high in the IDLE cycle after done starts a new transaction, so requester drops req on the edge where it sees done.
- adc_rst: from any state, next state IDLE, gnt/start/done/err_to all 0 next cycle, watchdog cleared, owner and cfg_data unchanged. Takes precedence over cfg_end and timeout in the same cycle.
- cfg_end and timeout in the same WAIT cycle: normal completion; err_to=0.
- Reset values: state IDLE; auto_gnt, sc_gnt, auto_done, sc_done, cfg_start, busy, err_to = 0; owner = 1 (so auto wins the first tie); cfg_data = 0; watchdog = 0.

## Timing
- All outputs registered.
- Req high at edge N (IDLE) -> GRANT at N+1: cfg_start, gnt, cfg_data valid.
- cfg_end at edge M (WAIT) -> done pulse at M+1, IDLE at M+2.
- Minimum transaction: 4 cycles IDLE->IDLE, with cfg_end returned on the first WAIT cycle.
- Back-to-back throughput: one transaction per (engine latency + 3) cycles.

## Configuration
- ADCARB_TIMEOUT_EN defined: watchdog counter present; WAIT exits at TO_CYCLES with err_to pulse and normal done pulse.
- Undefined: no counter; err_to tied 0; WAIT waits indefinitely for cfg_end or adc_rst.

## Structure
- Shared package: state encoding constants (IDLE=2'b00, GRANT=2'b01, WAIT=2'b11, DONE=2'b10), owner codes (OWN_AUTO=0, OWN_SC=1), default DATA_W.
- Optional sub-module adc_cfg_watchdog: counter with clear/enable/expire, instantiated only under ADCARB_TIMEOUT_EN.
- Rest is a single FSM plus registered datapath.

## Test plan
- Single auto: auto_req with auto_data=24'h0A1234, engine returns cfg_end 10 cycles after start -> cfg_start one cycle after req, cfg_data=24'h0A1234, auto_done 1 cycle after cfg_end, sc_gnt never high.
- Simultaneous first requests: auto_req and sc_req high at the same edge after reset, both held -> auto served first, sc served next, owner reads 0 then 1.
- Continuous contention: both held for 4 transactions -> grants alternate auto, sc, auto, sc; no requester starved.
- adc_rst mid-WAIT: assert adc_rst 3 cycles after cfg_start -> IDLE next cycle, no done pulse, busy=0; a re-issued req restarts normally.
- Timeout (ADCARB_TIMEOUT_EN, TO_CYCLES=15): cfg_end never returned -> err_to and owner's done pulse together, 15 cycles after entering WAIT; without the macro, busy stays high.
- cfg_end pulsed in the GRANT cycle plus a later real cfg_end -> the first is ignored; done follows the second only.
